// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop RXD synchronizer, start-bit validation at mid-bit, data/stop sampled at bit centres.
// DATA_READY/FRAME_ERR pulse CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles after the start edge; no backpressure.
module uart_recv #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       DATA_READY,
    output logic       FRAME_ERR,
    output logic       IDLE
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          rdy_q;
    logic          ferr_q;
    logic          meta_q;
    logic          rx_q;

    // Both stages reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q <= 1'b1;
            rx_q   <= 1'b1;
        end else begin
            meta_q <= RXD;
            rx_q   <= meta_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_q;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_q) begin
                            data_q  <= shift_q;
                            rdy_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before another start bit is accepted.
                    cnt_q <= '0;
                    if (rx_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign DATA       = data_q;
    assign DATA_READY = rdy_q;
    assign FRAME_ERR  = ferr_q;
    assign IDLE       = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Randomized and directed bench for uart_recv at 16 clocks per bit, checked against a frame-level model.
module tb_uart_recv;

    localparam int C   = 16;
    localparam int LAT = C / 2 + 9 * C + 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] DATA;
    logic       DATA_READY;
    logic       FRAME_ERR;
    logic       IDLE;

    uart_recv #(.CLKS_PER_BIT(C)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RXD       (RXD),
        .DATA      (DATA),
        .DATA_READY(DATA_READY),
        .FRAME_ERR (FRAME_ERR),
        .IDLE      (IDLE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         fall;
        logic [7:0] b;
        bit         ok;
    } frm_t;

    frm_t       expq[$];
    logic [7:0] model_last = 8'h00;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         prev_rdy = 0;
    int         last_rdy = 0;
    frm_t       mon_f;
    int         mon_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every output pulse must match the oldest frame the model has queued.
    always @(negedge CLK) begin
        if (!RST && (DATA_READY || FRAME_ERR)) begin
            chk("exclusive", 32'(DATA_READY && FRAME_ERR), 0);
            if (expq.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_f = expq.pop_front();
                mon_d = cyc - mon_f.fall;
                chk("kind", 32'(DATA_READY), 32'(mon_f.ok));
                chk("latency", (mon_d >= LAT - 1 && mon_d <= LAT + 1) ? LAT : mon_d, LAT);
                if (mon_f.ok) model_last = mon_f.b;
                chk("data", 32'(DATA), 32'(model_last));
            end
            if (DATA_READY) begin
                prev_rdy = last_rdy;
                last_rdy = cyc;
            end
        end
    end

    task automatic drive(input logic v, input int n);
        RXD = v;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        frm_t f;
        f.fall = cyc;
        f.b    = b;
        f.ok   = stop;
        expq.push_back(f);
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(b[i], C);
        drive(stop, C);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && expq.size() != 0; i++) @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("drain", expq.size(), 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_last = 8'h00;
    endtask

    initial begin
        int         ret;
        bit         low_seen;
        int         k;
        logic [7:0] rb;
        bit         rs;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_data", 32'(DATA), 0);
        chk("rst_rdy", 32'(DATA_READY), 0);
        chk("rst_ferr", 32'(FRAME_ERR), 0);
        chk("rst_idle", 32'(IDLE), 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(1'b1, 10);

        send_frame(8'h55, 1'b1);
        drive(1'b1, 10);
        wait_drain(400);
        chk("idle_after_55", 32'(IDLE), 1);
        chk("data_55", 32'(DATA), 32'h55);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 10);
        wait_drain(400);
        chk("b2b_gap", last_rdy - prev_rdy, 10 * C);
        chk("data_ff", 32'(DATA), 32'hFF);

        k = cyc;
        RXD = 1'b0;
        low_seen = 0;
        ret = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (cyc - k == 3) RXD = 1'b1;
            if (!IDLE) low_seen = 1;
            else if (low_seen && ret < 0) ret = cyc - k;
        end
        @(posedge CLK);
        #1;
        chk("glitch_idle_low", 32'(low_seen), 1);
        chk("glitch_idle_return", 32'(ret > 0 && ret <= 12), 1);
        drive(1'b1, 20);
        chk("glitch_data", 32'(DATA), 32'hFF);

        send_frame(8'h3C, 1'b1);
        drive(1'b1, 10);
        send_frame(8'hA5, 1'b0);
        drive(1'b0, 200);
        chk("break_idle_low", 32'(IDLE), 0);
        chk("break_data", 32'(DATA), 32'h3C);
        drive(1'b1, 4);
        chk("break_idle_high", 32'(IDLE), 1);
        send_frame(8'h81, 1'b1);
        drive(1'b1, 10);
        wait_drain(400);
        chk("data_81", 32'(DATA), 32'h81);

        // Abandon 0xC3 half-way through data bit 4.
        drive(1'b0, C);
        for (int i = 0; i < 4; i++) drive(rb_c3(i), C);
        drive(1'b0, C / 2);
        RXD = 1'b1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_last = 8'h00;
        @(negedge CLK);
        chk("midrst_data", 32'(DATA), 0);
        chk("midrst_idle", 32'(IDLE), 1);
        @(posedge CLK);
        #1;
        drive(1'b1, 200);
        chk("midrst_data_hold", 32'(DATA), 0);
        send_frame(8'h7E, 1'b1);
        drive(1'b1, 10);
        wait_drain(400);
        chk("data_7e", 32'(DATA), 32'h7E);

        for (int n = 0; n < 25; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs);
            if (!rs) begin
                drive(1'b0, $urandom_range(0, 40));
                drive(1'b1, $urandom_range(4, 20));
            end else begin
                drive(1'b1, $urandom_range(0, 15));
            end
        end
        drive(1'b1, 10);
        wait_drain(400);
        chk("final_data", 32'(DATA), 32'(model_last));

        do_reset();
        @(negedge CLK);
        chk("final_rst_data", 32'(DATA), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    function automatic logic rb_c3(input int i);
        logic [7:0] v;
        v = 8'hC3;
        return v[i];
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
